// File: rtl/spi_ctrl_tx.sv
// spi_ctrl_tx: SPI mode-0 write-only master. Each accepted request sends a
// 16-bit frame {1'b1, addr[6:0], data[7:0]}, MSB first, then holds nCS high
// for CS_GAP cycles before the next request can be taken.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready request handshake (ready only while idle)
//   in_addr, in_data  register address / write data, latched on accept
//   SCLK, COPI, nCS   SPI bus (SCLK idle low, nCS active low)
//   busy              high from the cycle after accept to the end of the gap
//   done              one-cycle pulse on the last gap cycle
//   err               one-cycle pulse on a rejected address
//
// Optional feature: define SPI_TX_ADDR_CHECK_EN to reject requests whose
// address exceeds MAX_ADDR; without it err is constant 0.
module spi_ctrl_tx #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CS_GAP      = 8,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_addr,
  input  logic [7:0] in_data,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ncs_q, ncs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rdy_q, rdy_d;
  logic        addr_bad;

`ifdef SPI_TX_ADDR_CHECK_EN
  assign addr_bad = {25'd0, in_addr} > MAX_ADDR;
`else
  logic unused_max_addr;
  assign unused_max_addr = |MAX_ADDR;
  assign addr_bad        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = {1'b1, in_addr, in_data};
          end
        end
      end
      LOW: begin
        if (cnt_q == HP_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (cnt_q == HP_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HP_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so every pin
    // comes straight from a flop and changes together with the state.
    sclk_d = (state_d == HIGH);
    ncs_d  = !((state_d == LOW) || (state_d == HIGH) || (state_d == HOLD));
    copi_d = ((state_d == LOW) || (state_d == HIGH)) && shift_d[15];
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == IDLE);
    done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign SCLK     = sclk_q;
  assign COPI     = copi_q;
  assign nCS      = ncs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// Self-checking bench for spi_ctrl_tx: a bus monitor reconstructs frames from
// SCLK/COPI/nCS and the directed sequence compares them with frames built
// from the request fields.
module tb_spi_ctrl_tx;
  localparam int HP   = 4;
  localparam int GAPC = 8;
  localparam int MAXA = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_addr;
  logic [7:0] in_data;
  logic       SCLK, COPI, nCS, busy, done, err;

  int total = 0;
  int bad   = 0;

  spi_ctrl_tx #(.HALF_PERIOD(HP), .CS_GAP(GAPC), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .SCLK(SCLK), .COPI(COPI),
    .nCS(nCS), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- bus monitor ----------------
  logic [15:0] fr_q[$];
  int          edge_q[$];
  int          len_q[$];
  logic [7:0]  rx_regs[128];
  logic [15:0] bits;
  int edges, low_run, high_run, last_gap, done_pos;
  int done_cnt = 0, err_cnt = 0, viol = 0, low_total = 0;
  logic p_ncs, p_sclk, p_copi;

  initial begin
    bits = '0; edges = 0; low_run = 0; high_run = 0; last_gap = 0; done_pos = 0;
    p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
    for (int i = 0; i < 128; i++) rx_regs[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bits = '0; edges = 0; low_run = 0; high_run = 0;
        p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
      end else begin
        if (err) err_cnt++;
        if (nCS) begin
          if (!p_ncs) begin
            fr_q.push_back(bits);
            edge_q.push_back(edges);
            len_q.push_back(low_run);
            rx_regs[bits[14:8]] = bits[7:0];
          end
          high_run++;
          if (SCLK) viol++;
        end else begin
          if (p_ncs) begin
            last_gap = high_run; high_run = 0; bits = '0; edges = 0; low_run = 0;
          end
          low_run++;
          low_total++;
          if (!busy) viol++;
          if (SCLK && !p_sclk) begin
            bits = {bits[14:0], COPI};
            edges++;
          end
          // data may move only where SCLK falls (entry to LOW or HOLD)
          if (!p_ncs && (COPI !== p_copi) && !(p_sclk && !SCLK)) viol++;
        end
        if (done) begin
          done_cnt++;
          done_pos = nCS ? high_run : -1;
        end
        p_ncs = nCS; p_sclk = SCLK; p_copi = COPI;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_addr(input logic [6:0] a);
`ifdef SPI_TX_ADDR_CHECK_EN
    return int'(a) <= MAXA;
`else
    return 1'b1;
`endif
  endfunction

  int exp_err = 0;

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 400) begin tick(); k++; end
    chk("ready_wait", 32'(k < 400), 1);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    int n0, d0, lt0, k;
    logic ok;
    ok = legal_addr(a);
    n0 = fr_q.size(); d0 = done_cnt; lt0 = low_total;
    in_valid = 1'b1; in_addr = a; in_data = d;
    wait_ready();
    tick();
    in_valid = 1'b0;
    if (ok) begin
      chk("start_ncs", nCS, 0);
      chk("start_sclk", SCLK, 0);
      chk("start_copi", COPI, 1);
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 0);
      k = 0;
      while (done_cnt == d0 && k < 400) begin tick(); k++; end
      chk("done_wait", 32'(k < 400), 1);
      chk("frame_count", fr_q.size(), n0 + 1);
      if (fr_q.size() > n0) begin
        chk("frame_bits", fr_q[n0], {1'b1, a, d});
        chk("frame_edges", edge_q[n0], 16);
        chk("frame_ncs_low", len_q[n0], 33 * HP);
      end
      chk("done_once", done_cnt, d0 + 1);
      chk("done_pos", done_pos, GAPC);
    end else begin
      exp_err++;
      chk("err_pulse", err, 1);
      chk("err_ncs", nCS, 1);
      chk("err_ready", in_ready, 1);
      tick();
      chk("err_one_cycle", err, 0);
      repeat (40) tick();
      chk("err_no_frame", fr_q.size(), n0);
      chk("err_ncs_never_low", low_total, lt0);
    end
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, d0, k;
    logic [7:0] wd[5];
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    repeat (3) tick();
    chk("rst_sclk", SCLK, 0);
    chk("rst_copi", COPI, 0);
    chk("rst_ncs", nCS, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1);

    // basic frame
    do_write(7'h02, 8'hA5);

    // back-to-back with in_valid held; inputs change mid-frame
    n0 = fr_q.size(); d0 = done_cnt;
    in_valid = 1'b1; in_addr = 7'h00; in_data = 8'h11;
    wait_ready();
    tick();
    in_addr = 7'h04; in_data = 8'hFF;
    wait_ready();
    tick();
    in_valid = 1'b0;
    k = 0;
    while (done_cnt < d0 + 2 && k < 800) begin tick(); k++; end
    chk("b2b_wait", 32'(k < 800), 1);
    chk("b2b_count", fr_q.size(), n0 + 2);
    if (fr_q.size() >= n0 + 2) begin
      chk("b2b_frame0", fr_q[n0], 16'h8011);
      chk("b2b_frame1", fr_q[n0 + 1], 16'h84FF);
    end
    chk("b2b_gap", last_gap, GAPC + 1);
    tick();

    // in-frame input changes and in_valid pulses are ignored
    n0 = fr_q.size(); d0 = done_cnt;
    in_valid = 1'b1; in_addr = 7'h03; in_data = 8'h5A;
    wait_ready();
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    in_addr = 7'h7F; in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    in_valid = 1'b1; in_addr = 7'h01;
    repeat (3) tick();
    in_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 400) begin tick(); k++; end
    chk("ign_wait", 32'(k < 400), 1);
    repeat (GAPC + 10) tick();
    chk("ign_count", fr_q.size(), n0 + 1);
    if (fr_q.size() > n0) chk("ign_frame", fr_q[n0], 16'h835A);
    chk("ign_ncs", nCS, 1);
    chk("ign_ready", in_ready, 1);

    // reset at the 7th SCLK rising edge
    n0 = fr_q.size(); d0 = done_cnt;
    in_valid = 1'b1; in_addr = 7'h2B; in_data = 8'hC3;
    wait_ready();
    tick();
    in_valid = 1'b0;
    k = 0;
    while (edges < 7 && k < 400) begin tick(); k++; end
    chk("edge7_wait", 32'(k < 400), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", nCS, 1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_copi", COPI, 0);
    chk("abort_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_frame", fr_q.size(), n0);
    chk("post_rst_ready", in_ready, 1);
    do_write(7'h01, 8'h96);

    // out-of-range address (transmitted unless address checking is built in)
    do_write(7'h05, 8'h3C);

    // random requests
    for (int i = 0; i < 6; i++) do_write(7'($urandom_range(0, 127)), 8'($urandom));

    // register-file loopback over the legal address range
    for (int i = 0; i < 5; i++) begin
      wd[i] = 8'($urandom);
      do_write(7'(i), wd[i]);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("loop_reg%0d", i), rx_regs[i], wd[i]);

    chk("err_total", err_cnt, exp_err);
    chk("protocol_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
